// File: rtl/result_seg7_driver.sv
`default_nettype none
// ============================================================================
// Module   : result_seg7_driver
// Brief    : Shows a 9-bit result in decimal on a 4-digit common-anode
//            seven-segment display (double-dabble + refresh multiplexer).
// Revision : 1.0 - initial release
// ============================================================================
module result_seg7_driver #(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] result,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int              C_REF_W    = $clog2(DIGIT_CYCLES);
    localparam logic [C_REF_W-1:0] C_REF_LAST = C_REF_W'(DIGIT_CYCLES - 1);
    localparam logic [6:0]      C_BLANK    = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         bin_q, bin_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         hund_q, hund_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic [C_REF_W-1:0] ref_q, ref_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               dp_q, dp_d;
    logic [11:0]        bcd_adj;
    logic [3:0]         digit;
    logic               blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return C_BLANK;
        endcase
    endfunction

    // Double-dabble converter; display registers are written only in LATCH
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        case (state_q)
            ST_IDLE: begin
                bin_d   = result;
                bcd_d   = '0;
                cnt_d   = 4'd9;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d = {bcd_adj[10:0], bin_q[8]};
                bin_d = {bin_q[7:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Refresh multiplexer; anode and segments are registered together
    always_comb begin
        ref_d = (ref_q == C_REF_LAST) ? '0 : ref_q + C_REF_W'(1);
        idx_d = (ref_q == C_REF_LAST) ? idx_q + 2'd1 : idx_q;
        digit = ones_q;
        blank = 1'b0;
        case (idx_q)
            2'd0: begin
                digit = ones_q;
                blank = 1'b0;
            end
            2'd1: begin
                digit = tens_q;
                blank = (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                digit = hund_q;
                blank = (hund_q == 4'd0);
            end
            default: begin
                digit = 4'd0;
                blank = 1'b1;
            end
        endcase
        seg_d = blank ? C_BLANK : seg_decode(digit);
        an_d  = ~(4'b0001 << idx_q);
        dp_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            seg_q   <= C_BLANK;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire
